// File: rtl/ps2_key_event_fifo_pkg.sv
// Shared types and constants for the PS/2 Set-2 key event path.
// Covers the event record, the prefix and drop-list bytes, and the decoder states.
package ps2_pkg;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } key_event_t;

    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;

    // Controller replies and error codes that never describe a key.
    localparam logic [7:0] PS2_DROP_NUL  = 8'h00;
    localparam logic [7:0] PS2_DROP_BAT  = 8'hAA;
    localparam logic [7:0] PS2_DROP_ECHO = 8'hEE;
    localparam logic [7:0] PS2_DROP_ACK  = 8'hFA;
    localparam logic [7:0] PS2_DROP_RSND = 8'hFE;
    localparam logic [7:0] PS2_DROP_ERR  = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } dec_state_t;

    function automatic logic is_drop(input logic [7:0] c);
        return c inside {PS2_DROP_NUL, PS2_DROP_BAT, PS2_DROP_ECHO,
                         PS2_DROP_ACK, PS2_DROP_RSND, PS2_DROP_ERR};
    endfunction

    function automatic logic is_prefix(input logic [7:0] c);
        return c inside {PS2_PFX_EXT, PS2_PFX_BRK, PS2_PFX_PAUSE};
    endfunction

endpackage

// File: rtl/ps2_key_event_fifo_if.sv
// Event pop port: show-ahead head entry with a valid/ready handshake.
interface ps2_key_event_fifo_if;
    import ps2_pkg::*;

    key_event_t evt_data_o;
    logic       evt_valid_o;
    logic       evt_ready_i;

    modport master (output evt_data_o, output evt_valid_o, input evt_ready_i);
    modport slave  (input evt_data_o, input evt_valid_o, output evt_ready_i);

endinterface

// File: rtl/ps2_key_event_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO with extended-pointer full/empty detection.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_i,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   drop,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic             full, do_push, do_pop;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    assign wr_nxt  = wr_ptr + (AW+1)'(do_push);
    assign rd_nxt  = rd_ptr + (AW+1)'(do_pop);

    always_ff @(posedge clk) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            count  <= wr_nxt - rd_nxt;
        end
    end

    // Storage is left unreset so it maps onto LUT RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ps2_key_event_fifo.sv
// Collapses a PS/2 Set-2 byte stream into one event per key action
// and queues the events for the CPU behind a show-ahead FIFO.
module ps2_key_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int PAUSE_LEN = 7
) (
    input  logic                   clk,
    input  logic                   reset_i,
    input  logic [7:0]             ps2_code_i,
    input  logic                   ps2_strobe_i,
    input  logic                   ps2_err_i,
    ps2_key_event_fifo_if.master   evt,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o,
    output logic                   rx_err_o,
    input  logic                   clr_i
);
    localparam int PW = $clog2(PAUSE_LEN + 1);

    dec_state_t state, state_nxt, idle_nxt;
    logic [PW-1:0] pause_cnt, cnt_nxt;
    logic       push, idle_push, pfx, drop, empty;
    key_event_t evt_in, head;

    assign pfx = is_prefix(ps2_code_i);

    // What a byte means with no prefix pending; also used to resync on a stray prefix.
    always_comb begin
        idle_push = 1'b0;
        case (ps2_code_i)
            PS2_PFX_EXT:   idle_nxt = ST_EXT;
            PS2_PFX_BRK:   idle_nxt = ST_BRK;
            PS2_PFX_PAUSE: idle_nxt = ST_PAUSE;
            default: begin
                idle_nxt  = ST_IDLE;
                idle_push = ~is_drop(ps2_code_i);
            end
        endcase
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = pause_cnt;
        push        = 1'b0;
        evt_in.brk  = 1'b0;
        evt_in.ext  = 1'b0;
        evt_in.code = ps2_code_i;
        if (ps2_err_i) begin
            state_nxt = ST_IDLE;
        end else if (ps2_strobe_i) begin
            case (state)
                ST_IDLE: begin
                    state_nxt = idle_nxt;
                    push      = idle_push;
                    cnt_nxt   = '0;
                end
                ST_EXT: begin
                    if (ps2_code_i == PS2_PFX_BRK) begin
                        state_nxt = ST_EXT_BRK;
                    end else if (pfx) begin
                        state_nxt = idle_nxt;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt  = ST_IDLE;
                        push       = 1'b1;
                        evt_in.ext = 1'b1;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    if (pfx) begin
                        state_nxt = idle_nxt;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt  = ST_IDLE;
                        push       = 1'b1;
                        evt_in.brk = 1'b1;
                        evt_in.ext = (state == ST_EXT_BRK);
                    end
                end
                ST_PAUSE: begin
                    if (pause_cnt == PW'(PAUSE_LEN - 1)) begin
                        state_nxt   = ST_IDLE;
                        push        = 1'b1;
                        evt_in.ext  = 1'b1;
                        evt_in.code = PS2_PFX_PAUSE;
                    end else begin
                        cnt_nxt = pause_cnt + PW'(1);
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state      <= ST_IDLE;
            pause_cnt  <= '0;
            overflow_o <= 1'b0;
            rx_err_o   <= 1'b0;
        end else begin
            state      <= state_nxt;
            pause_cnt  <= cnt_nxt;
            // A new event on the same cycle as clr_i keeps the flag set.
            overflow_o <= (overflow_o & ~clr_i) | drop;
            rx_err_o   <= (rx_err_o & ~clr_i) | ps2_err_i;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(key_event_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_i (reset_i),
        .push    (push),
        .din     (evt_in),
        .pop     (evt.evt_ready_i),
        .dout    (head),
        .empty   (empty),
        .drop    (drop),
        .count   (count_o)
    );

    assign evt.evt_data_o  = head;
    assign evt.evt_valid_o = ~empty;

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Randomized and directed bench for ps2_key_event_fifo with a queue scoreboard
// fed by a byte-level reference model of the Set-2 prefix rules.
module tb_ps2_key_event_fifo;
    localparam int DEPTH     = 16;
    localparam int PAUSE_LEN = 7;

    logic                   clk = 1'b0;
    logic                   reset_i;
    logic [7:0]             ps2_code_i;
    logic                   ps2_strobe_i, ps2_err_i, clr_i;
    logic [$clog2(DEPTH):0] count_o;
    logic                   overflow_o, rx_err_o;

    ps2_key_event_fifo_if evt();

    ps2_key_event_fifo #(.DEPTH(DEPTH), .PAUSE_LEN(PAUSE_LEN)) dut (
        .clk          (clk),
        .reset_i      (reset_i),
        .ps2_code_i   (ps2_code_i),
        .ps2_strobe_i (ps2_strobe_i),
        .ps2_err_i    (ps2_err_i),
        .evt          (evt),
        .count_o      (count_o),
        .overflow_o   (overflow_o),
        .rx_err_o     (rx_err_o),
        .clr_i        (clr_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: expected FIFO contents plus pending-prefix bookkeeping.
    logic [9:0] exp_q[$];
    int m_cnt = 0;
    bit m_ovf = 0, m_rxe = 0;
    bit m_ext = 0, m_brk = 0;
    int m_pause_left = 0;

    function automatic bit drop_byte(input logic [7:0] c);
        return c == 8'h00 || c == 8'hAA || c == 8'hEE || c == 8'hFA || c == 8'hFE || c == 8'hFF;
    endfunction

    function automatic void model_byte(input logic [7:0] c, output bit emit, output logic [9:0] ev);
        emit = 0;
        ev   = '0;
        if (m_pause_left > 0) begin
            m_pause_left--;
            if (m_pause_left == 0) begin
                emit = 1;
                ev   = {2'b01, 8'hE1};
            end
        end else if (c == 8'hE0) begin
            m_ext = 1; m_brk = 0;
        end else if (c == 8'hF0) begin
            m_ext = m_ext && !m_brk;
            m_brk = 1;
        end else if (c == 8'hE1) begin
            m_pause_left = PAUSE_LEN;
            m_ext = 0; m_brk = 0;
        end else begin
            if (m_ext || m_brk || !drop_byte(c)) begin
                emit = 1;
                ev   = {m_brk, m_ext, c};
            end
            m_ext = 0; m_brk = 0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: check state left by the previous edge, then drive the next one.
    task automatic cycle(input bit rst, input bit stb, input logic [7:0] code,
                         input bit err, input bit rdy, input bit clr);
        bit         emit, pop;
        logic [9:0] ev;
        @(negedge clk);
        check("count_o", 32'(count_o), 32'(m_cnt));
        check("evt_valid_o", 32'(evt.evt_valid_o), 32'(m_cnt != 0));
        check("overflow_o", 32'(overflow_o), 32'(m_ovf));
        check("rx_err_o", 32'(rx_err_o), 32'(m_rxe));
        #1;
        reset_i         = rst;
        ps2_strobe_i    = stb;
        ps2_code_i      = code;
        ps2_err_i       = err;
        clr_i           = clr;
        evt.evt_ready_i = rdy && !rst;
        if (rst) begin
            exp_q.delete();
            m_cnt = 0; m_ovf = 0; m_rxe = 0;
            m_ext = 0; m_brk = 0; m_pause_left = 0;
        end else begin
            emit = 0;
            ev   = '0;
            if (err) begin
                m_ext = 0; m_brk = 0; m_pause_left = 0;
            end else if (stb) begin
                model_byte(code, emit, ev);
            end
            pop   = rdy && m_cnt > 0;
            m_ovf = m_ovf && !clr;
            m_rxe = (m_rxe && !clr) || err;
            if (emit) begin
                if (m_cnt == DEPTH && !pop) m_ovf = 1;
                else begin
                    exp_q.push_back(ev);
                    m_cnt++;
                end
            end
            if (pop) m_cnt--;
        end
    endtask

    task automatic send(input logic [7:0] code, input bit rdy);
        cycle(0, 1, code, 0, rdy, 0);
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 0, rdy, 0);
    endtask

    // Monitor: each accepted pop must match the oldest expected event.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset_i === 1'b0 && evt.evt_valid_o === 1'b1 && evt.evt_ready_i === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL evt_data_o: got %0h expected no event at %0t", evt.evt_data_o, $time);
                end else begin
                    check("evt_data_o", 32'(evt.evt_data_o), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [7:0] dl [6];
        logic [7:0] code;
        int         rp;
        dl = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
        reset_i = 1; ps2_strobe_i = 0; ps2_code_i = 0; ps2_err_i = 0; clr_i = 0;
        evt.evt_ready_i = 0;
        repeat (2) @(negedge clk);
        cycle(1, 0, 8'h00, 0, 0, 0);

        // Make and break of a plain key
        send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0);
        idle(0, 2); idle(1, 4);
        // Extended make and break
        send(8'hE0, 0); send(8'h75, 0); send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
        idle(1, 4);
        // Pause sequence then a plain key
        send(8'hE1, 0); send(8'h14, 0); send(8'h77, 0); send(8'hE1, 0);
        send(8'hF0, 0); send(8'h14, 0); send(8'hF0, 0); send(8'h77, 0); send(8'h1C, 0);
        idle(1, 4);
        // Framing error cancels a pending prefix and wins over a coincident strobe
        send(8'hE0, 0); cycle(0, 1, 8'h55, 1, 0, 0); send(8'h1C, 0);
        idle(0, 1); cycle(0, 0, 8'h00, 0, 0, 1); idle(1, 4);
        // Fill past capacity, then push with a pop on a full FIFO
        for (int i = 1; i <= DEPTH + 1; i++) send(8'(i), 0);
        idle(0, 1); cycle(0, 0, 8'h00, 0, 0, 1);
        send(8'h22, 1);
        idle(1, DEPTH + 4);
        // Reset in the middle of a break prefix with an entry queued
        send(8'h1C, 0); send(8'hF0, 0); cycle(1, 0, 8'h00, 0, 0, 0);
        send(8'h1C, 0); idle(1, 4);

        rp = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                case ($urandom_range(0, 2))
                    0: rp = 0;
                    1: rp = 30;
                    default: rp = 90;
                endcase
            end
            case ($urandom_range(0, 9))
                0: code = 8'hE0;
                1: code = 8'hF0;
                2: code = 8'hE1;
                3: code = dl[$urandom_range(0, 5)];
                default: code = 8'($urandom);
            endcase
            cycle($urandom_range(0, 999) < 3, $urandom_range(0, 1) == 1, code,
                  $urandom_range(0, 99) < 2, $urandom_range(0, 99) < rp,
                  $urandom_range(0, 99) < 3);
        end

        idle(1, DEPTH + 4);
        check("drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_fifo.md
Name: ps2_key_event_fifo

Overview:
- Sits between the PS/2 receiver (ps2kbd) and the SoC keyboard register port.
- Consumes the raw byte/strobe/error stream.
- Decodes Set-2 prefix sequences (E0, F0, E1 Pause) into single key events, one per key action.
- Buffers events in a show-ahead FIFO with a valid/ready pop handshake, so the CPU can poll without losing keys.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- PAUSE_LEN, 7, bytes that follow E1 in the Pause sequence and are swallowed.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_i  in  1  synchronous, active-high reset.
- ps2_code_i  in  8  received byte; valid only when ps2_strobe_i=1.
- ps2_strobe_i  in  1  one-cycle byte-valid pulse.
- ps2_err_i  in  1  one-cycle framing/parity error pulse.
- evt_data_o  out  10  head event: [9]=break, [8]=extended, [7:0]=code.
- evt_valid_o  out  1  FIFO not empty; evt_data_o is valid.
- evt_ready_i  in  1  pop; takes effect when evt_valid_o=1, ignored otherwise.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- overflow_o  out  1  sticky: an event was dropped because the FIFO was full.
- rx_err_o  out  1  sticky: ps2_err_i was seen.
- clr_i  in  1  one-cycle pulse; clears overflow_o and rx_err_o. FIFO contents are untouched.

Behaviour:
- Reset values: all outputs 0, FIFO empty, decoder in IDLE. Reset mid-sequence discards any partial prefix state.
- Decoder FSM advances only on ps2_strobe_i.
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - E1 -> PAUSE, count=0.
    - 00, AA, EE, FA, FE, FF -> dropped, stay IDLE.
    - Any other byte -> push {0,0,code}, stay IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - E0 or E1 -> resync: treat the byte as if received in IDLE.
    - Other byte -> push {0,1,code}, go IDLE.
  - BRK:
    - Non-prefix byte -> push {1,0,code}, go IDLE.
    - Prefix byte -> resync as in IDLE.
  - EXT_BRK:
    - Any byte except E0/E1/F0 -> push {1,1,code}, go IDLE.
    - Prefix byte -> resync as in IDLE.
    - Fake-shift codes (E0 12 / E0 F0 12) are pushed as normal events; no filtering.
  - PAUSE:
    - Swallow bytes, incrementing count.
    - When count reaches PAUSE_LEN-1 on a strobe, push {0,1,E1}, go IDLE.
- ps2_err_i has priority over ps2_strobe_i in the same cycle: byte is ignored, FSM -> IDLE, rx_err_o<=1.
- clr_i and a new error in the same cycle: the flag stays set (set wins).
- Push timing: push occurs in the same cycle as the completing strobe. If the FIFO was empty, evt_valid_o rises the next cycle (latency 1).
- Pop: evt_valid_o & evt_ready_i advances the read pointer. The next entry is on evt_data_o the following cycle.
- Full FIFO:
  - Push with a simultaneous pop is accepted; count is unchanged.
  - Push without a pop drops the event, sets overflow_o, and leaves contents unchanged.
- Empty FIFO with a simultaneous push and pop: the pop is ignored (valid was 0) and the push lands; count=1.
- Pointers are $clog2(DEPTH)+1 bits with natural wrap. Full = MSBs differ and the rest are equal.
- count_o = wr_ptr - rd_ptr, registered, exact every cycle.
- Storage: distributed/LUT RAM, asynchronous read at rd_ptr (show-ahead).

Decomposition:
- Package ps2_pkg:
  - key_event_t packed struct {brk, ext, code[7:0]}.
  - Constants PS2_PFX_EXT=8'hE0, PS2_PFX_BRK=8'hF0, PS2_PFX_PAUSE=8'hE1.
  - Constants for the drop list (00, AA, EE, FA, FE, FF).
  - Decoder state enum.
- Sub-module sync_fifo #(WIDTH, DEPTH): push/pop/full/empty/count with the full-with-pop rule above. It is reusable for the UART receive path.
- The decoder FSM lives in ps2_key_event_fifo itself.

Test Plan:
- Bytes 1C; F0 1C -> two events 0x01C then 0x21C, in order. evt_valid_o rises 1 cycle after the first strobe.
- E0 75; E0 F0 75 -> events 0x175 then 0x375.
- E1 14 77 E1 F0 14 F0 77 -> exactly one event 0x1E1. A following 1C yields 0x01C.
- E0, then ps2_err_i, then 1C -> single event 0x01C (no extended bit). rx_err_o=1; clr_i -> 0.
- Push 17 events with evt_ready_i=0, DEPTH=16 -> count_o=16, overflow_o=1. Popping returns the first 16 codes in order.
- With FIFO full, push and pop in the same cycle -> count_o stays 16, overflow_o stays 0, and the new event comes out last.
- Assert reset_i after F0 with a pending entry -> count_o=0, evt_valid_o=0. A following 1C yields 0x01C, not a break.
